// File: rtl/mon_prod_par.sv
// Radix-2 Montgomery product P = A*B*2^-k mod n, operands fetched from a synchronous-read memory.
// Define MON_PROD_FINAL_SUB_EN to enable the final conditional subtraction of n in STORE.
module mon_prod_par #(
  parameter int WIDTH  = 256,
  parameter int ABITS  = 8,
  parameter int X_ADDR = 0,
  parameter int M_ADDR = 2,
  parameter int R_ADDR = 0,
  localparam int CBITS = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op_code,
  input  logic [WIDTH-1:0] n,
  input  logic [CBITS-1:0] mp_count,
  output logic [ABITS-1:0] rd_addr,
  input  logic [WIDTH-1:0] rd_data,
  output logic [ABITS-1:0] wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             wr_en,
  output logic             busy,
  output logic             stop,
  output logic             err,
  output logic [WIDTH:0]   P
);

  typedef enum logic [2:0] {
    IDLE, RDA, LDA, RDB, LDB, CALC, STORE, DONE
  } state_t;

  localparam logic [1:0] OPXX = 2'd0;
  localparam logic [1:0] OPXM = 2'd1;
  localparam logic [1:0] OPX1 = 2'd2;
  localparam logic [1:0] OPRS = 2'd3;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic [WIDTH:0]     p_reg;
  logic [CBITS-1:0]   cnt_reg;
  logic [1:0]         op_reg;
  logic               err_reg;
  logic [ABITS-1:0]   rd_addr_reg;

  logic               req_bad;
  logic [WIDTH+1:0]   t_add, t_sum;
  logic [WIDTH:0]     p_step, p_fin;

  assign req_bad = (op_code == OPRS) || (mp_count == '0) ||
                   (mp_count > CBITS'(WIDTH));

  // One radix-2 step; WIDTH+2 bits hold P + A + n without overflow when P < 2n.
  assign t_add  = {1'b0, p_reg} + (b_reg[0] ? {2'b00, a_reg} : '0);
  assign t_sum  = t_add[0] ? (t_add + {2'b00, n}) : t_add;
  assign p_step = t_sum[WIDTH+1:1];

`ifdef MON_PROD_FINAL_SUB_EN
  assign p_fin = (p_reg >= {1'b0, n}) ? (p_reg - {1'b0, n}) : p_reg;
`else
  assign p_fin = p_reg;
`endif

  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    stop       = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = req_bad ? DONE : RDA;
      end
      RDA:  state_next = LDA;
      LDA:  state_next = (op_reg == OPXM) ? RDB : CALC;
      RDB:  state_next = LDB;
      LDB:  state_next = CALC;
      CALC: if (cnt_reg == CBITS'(1)) state_next = STORE;
      STORE: begin
        wr_en      = 1'b1;
        wr_addr    = ABITS'(R_ADDR);
        wr_data    = p_fin[WIDTH-1:0];
        state_next = DONE;
      end
      DONE: begin
        stop       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      p_reg       <= '0;
      cnt_reg     <= '0;
      op_reg      <= '0;
      err_reg     <= 1'b0;
      rd_addr_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (start) begin
          p_reg   <= '0;
          err_reg <= req_bad;
          if (!req_bad) begin
            op_reg      <= op_code;
            cnt_reg     <= mp_count;
            rd_addr_reg <= ABITS'(X_ADDR);
          end
        end
        LDA: begin
          a_reg <= rd_data;
          case (op_reg)
            OPXX:    b_reg <= rd_data;
            OPX1:    b_reg <= WIDTH'(1);
            OPXM:    rd_addr_reg <= ABITS'(M_ADDR);
            default: b_reg <= b_reg;
          endcase
        end
        LDB:  b_reg <= rd_data;
        CALC: begin
          p_reg   <= p_step;
          b_reg   <= b_reg >> 1;
          cnt_reg <= cnt_reg - CBITS'(1);
        end
        STORE: p_reg <= p_fin;
        default: ;
      endcase
    end
  end

  assign rd_addr = rd_addr_reg;
  assign err     = err_reg;
  assign P       = p_reg;

endmodule

// File: doc/mon_prod_par.md
MON_PROD_PAR -- requirements
Module: mon_prod_par

Interface
REQ-001 Parameter WIDTH, default 256: modulus/operand width in bits.
REQ-002 Parameter ABITS, default 8: memory address width.
REQ-003 Parameters X_ADDR (default 0), M_ADDR (default 2), R_ADDR (default 0): operand X, operand M and result word addresses.
REQ-004 Localparam CBITS = $clog2(WIDTH)+1: iteration-count width.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  reset; synchronous, active-low.
REQ-007 start  in  1  request; sampled only in IDLE.
REQ-008 op_code  in  2  0=OPXX (X*X), 1=OPXM (X*M), 2=OPX1 (X*1), 3=reserved.
REQ-009 n  in  WIDTH  odd modulus; held stable from start until stop.
REQ-010 mp_count  in  CBITS  iteration count k (R = 2^k); captured at start.
REQ-011 rd_addr  out  ABITS  registered read address.
REQ-012 rd_data  in  WIDTH  read data, valid the cycle after rd_addr presents the address.
REQ-013 wr_addr / wr_data / wr_en  out  ABITS / WIDTH / 1  result write port.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 stop  out  1  one-cycle done pulse.
REQ-016 err  out  1  error flag, valid with stop, held until next accepted start.
REQ-017 P  out  WIDTH+1  result, held until next accepted start.

Function
REQ-018 States: IDLE, RDA, LDA, RDB, LDB, CALC, STORE, DONE.
REQ-019 IDLE with start=1 and op_code 0..2: capture op_code and k, clear P and err, rd_addr<=X_ADDR, go to RDA.
REQ-020 RDA -> LDA; LDA: A<=rd_data; B<=rd_data (OPXX), 1 (OPX1); OPXM: rd_addr<=M_ADDR, go to RDB, else go to CALC.
REQ-021 RDB -> LDB; LDB: B<=rd_data, go to CALC.
REQ-022 Each CALC cycle (radix-2): T = P + (B[0] ? A : 0); if T odd, T = T + n; P <= T >> 1; B <= B >> 1; count decrements; internal T width WIDTH+2, no overflow.
REQ-023 CALC lasts exactly k cycles, then STORE.
REQ-024 STORE: apply final step (REQ-037/038), wr_en=1, wr_addr=R_ADDR, wr_data=P[WIDTH-1:0] for this one cycle only; go to DONE.
REQ-025 DONE: stop=1 one cycle, go to IDLE.
REQ-026 Latency start->stop: k+4 cycles (OPXX/OPX1), k+6 (OPXM).
REQ-027 start while busy ignored; no queuing.
REQ-028 op_code=3: no memory access, no write; next cycle DONE with err=1.
REQ-029 k=0 or k>WIDTH: no memory access, no write, P=0, err=1, stop per REQ-028 timing.
REQ-030 wr_en asserted only in STORE; rd_addr changes only on load transitions.
REQ-031 Valid inputs (A,B<n, k=WIDTH) guarantee pre-correction P<2n.

Reset
REQ-032 rst_n=0 at a clock edge forces IDLE regardless of state, including mid-CALC.
REQ-033 Reset values: rd_addr=0, wr_addr=0, wr_data=0, wr_en=0, busy=0, stop=0, err=0, P=0, internal A/B/count=0.
REQ-034 Operation aborted by reset produces no write and no stop.
REQ-035 start in the first cycle after rst_n releases is accepted normally.

Configuration
REQ-036 Macro MON_PROD_FINAL_SUB_EN controls final conditional subtraction.
REQ-037 Defined: in STORE, if P>=n then P<=P-n; result in [0,n).
REQ-038 Undefined: no subtraction; P in [0,2n) returned raw, bit WIDTH may be set; wr_data carries low WIDTH bits.

Verification (WIDTH=8, n=13, k=4, macro defined unless noted)
REQ-039 OPX1, mem[0]=5 -> P=6, write mem[0]=6, stop at cycle 8 after start.
REQ-040 OPXX, mem[0]=7 -> P=12; OPXM, mem[0]=5, mem[2]=4 -> P=11, stop at cycle 10.
REQ-041 OPXX, mem[0]=9 -> P=1 with macro; P=14 (9'h00E) without.
REQ-042 op_code=3, or k=0 -> err=1, stop 1 cycle later, wr_en never high.
REQ-043 rst_n=0 in 2nd CALC cycle -> all outputs at reset values next cycle, no write; start during busy ignored.
